// File: rtl/pixel_frame_store_if.sv
// Plot/scanout bus between the game logic (master) and the pixel frame store (slave).
interface pixel_frame_store_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       clear_req;
  logic       scan_en;
  logic       busy;
  logic       clear_done;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       line_start;
  logic       frame_start;
  logic [7:0] drop_count;

  modport master (
    output x, y, colour, plot, clear_req, scan_en,
    input  busy, clear_done, pix_valid, pix_x, pix_y, pix_colour,
           line_start, frame_start, drop_count
  );

  modport slave (
    input  x, y, colour, plot, clear_req, scan_en,
    output busy, clear_done, pix_valid, pix_x, pix_y, pix_colour,
           line_start, frame_start, drop_count
  );
endinterface

// File: rtl/pixel_frame_store.sv
// WIDTHxHEIGHT 3-bit frame store: plot writes, clear fill, raster scanout with
// registered (read-first) reads, and a saturating rejected-write counter.
module pixel_frame_store #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter int         PIX_DIV   = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic                clock,
  input logic                resetn,
  pixel_frame_store_if.slave bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int DW   = $clog2(PIX_DIV);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [14:0] clr_q, clr_d;
  logic        done_q, done_d;
  logic [7:0]  drop_q;

  logic [2:0]  mem [NPIX];

  logic        in_range, we;
  logic [14:0] paddr, waddr, raddr;
  logic [2:0]  wdata;

  logic [DW-1:0] div_q;
  logic [7:0]    sx_q, pix_x_q;
  logic [6:0]    sy_q, pix_y_q;
  logic [2:0]    rd_q;
  logic          vld_q, ls_q, fs_q, tick;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      clr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        clr_d = '0;
        if (bus.clear_req) state_d = CLEAR;
      end
      CLEAR: begin
        if (clr_q == 15'(NPIX - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + 15'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- write path ----------------
  assign in_range = (bus.x < 8'(WIDTH)) && (bus.y < 7'(HEIGHT));
  assign paddr    = 15'(bus.y) * 15'(WIDTH) + 15'(bus.x);
  assign we       = (state_q == CLEAR) || (bus.plot && in_range);
  assign waddr    = (state_q == CLEAR) ? clr_q : paddr;
  assign wdata    = (state_q == CLEAR) ? BG_COLOUR : bus.colour;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Plots are refused both off-screen and while the clear owns the write port.
  always_ff @(posedge clock) begin
    if (!resetn)
      drop_q <= '0;
    else if (bus.plot && ((state_q == CLEAR) || !in_range) && (drop_q != 8'hff))
      drop_q <= drop_q + 8'd1;
  end

  // ---------------- scanout ----------------
  assign tick  = bus.scan_en && (div_q == DW'(PIX_DIV - 1));
  assign raddr = 15'(sy_q) * 15'(WIDTH) + 15'(sx_q);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      div_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      vld_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      rd_q    <= '0;
    end else if (!bus.scan_en) begin
      div_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      vld_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      vld_q <= tick;
      ls_q  <= tick && (sx_q == '0);
      fs_q  <= tick && (sx_q == '0) && (sy_q == '0);
      if (tick) begin
        div_q   <= '0;
        pix_x_q <= sx_q;
        pix_y_q <= sy_q;
        // Non-blocking read against the write block gives read-first on collision.
        rd_q    <= mem[raddr];
        if (sx_q == 8'(WIDTH - 1)) begin
          sx_q <= '0;
          sy_q <= (sy_q == 7'(HEIGHT - 1)) ? 7'd0 : sy_q + 7'd1;
        end else begin
          sx_q <= sx_q + 8'd1;
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  assign bus.busy        = (state_q == CLEAR);
  assign bus.clear_done  = done_q;
  assign bus.pix_valid   = vld_q & bus.scan_en;
  assign bus.line_start  = ls_q & bus.scan_en;
  assign bus.frame_start = fs_q & bus.scan_en;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.pix_colour  = rd_q;
  assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_pixel_frame_store.sv
// Scoreboard bench: stimulus pushes expected scanout pixels from a flat frame model,
// an independent monitor pops and compares every pix_valid.
module tb_pixel_frame_store;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int PD = 2;
  localparam int N  = W * H;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  pixel_frame_store_if bus();

  pixel_frame_store #(.WIDTH(W), .HEIGHT(H), .PIX_DIV(PD), .BG_COLOUR(3'b000)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       ls;
    logic       fs;
  } pix_t;

  pix_t       exp_q[$];
  logic [2:0] ref_mem [N];
  int         ref_drop = 0;
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // One-cycle plot; the model applies the documented accept/reject rules.
  task automatic plot1(input int px, input int py, input logic [2:0] c, input bit in_clear);
    bus.x = 8'(px); bus.y = 7'(py); bus.colour = c; bus.plot = 1'b1;
    if (!in_clear && px < W && py < H) ref_mem[py * W + px] = c;
    else if (ref_drop < 255) ref_drop++;
    step;
    bus.plot = 1'b0;
  endtask

  task automatic push_raster(input int count);
    for (int i = 0; i < count; i++) begin
      pix_t e;
      int idx;
      idx  = i % N;
      e.x  = 8'(idx % W);
      e.y  = 7'(idx / W);
      e.c  = ref_mem[idx];
      e.ls = (idx % W) == 0;
      e.fs = idx == 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < (N + 4) * PD + 100) begin
      step;
      t++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: pops one expected pixel per pix_valid and checks the pixel period.
  initial begin
    int last_v;
    pix_t e, g;
    last_v = -1;
    forever begin
      @(negedge clock);
      if (!bus.scan_en) last_v = -1;
      if (resetn && bus.pix_valid) begin
        g = {bus.pix_x, bus.pix_y, bus.pix_colour, bus.line_start, bus.frame_start};
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pix_unexpected: got (%0d,%0d)=%0d, expected no pixel", g.x, g.y, g.c);
        end else begin
          e = exp_q.pop_front();
          if (g != e) begin
            n_fail++;
            $display("FAIL pix: got (%0d,%0d)=%0d ls=%0d fs=%0d, expected (%0d,%0d)=%0d ls=%0d fs=%0d",
                     g.x, g.y, g.c, g.ls, g.fs, e.x, e.y, e.c, e.ls, e.fs);
          end
        end
        if (last_v >= 0) chk("pix_period", cyc - last_v, PD);
        last_v = cyc;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, cnt;
    bus.x = '0; bus.y = '0; bus.colour = '0; bus.plot = 1'b0;
    bus.clear_req = 1'b0; bus.scan_en = 1'b0;

    // Reset state
    resetn = 1'b0;
    step; step;
    chk("rst_busy", bus.busy, 0);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_drop", bus.drop_count, 0);
    chk("rst_pix_x", bus.pix_x, 0);
    chk("rst_pix_y", bus.pix_y, 0);
    chk("rst_clear_done", bus.clear_done, 0);
    resetn = 1'b1;
    step;

    // Clear aborted by reset at busy cycle 1000
    bus.clear_req = 1'b1; step; bus.clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    while (bus.busy && busy_cnt < 1000) begin
      busy_cnt++;
      step;
    end
    chk("abort_busy_cycles", busy_cnt, 1000);
    resetn = 1'b0; step; resetn = 1'b1;
    ref_drop = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.clear_done, 0);
    for (int i = 0; i < 5; i++) begin
      if (bus.clear_done) done_cnt++;
      step;
    end
    chk("abort_no_done", done_cnt, 0);

    // Full clear, with a plot and a stray clear_req mid-clear
    plot1(20, 20, 3'b010, 1'b0);
    bus.clear_req = 1'b1; step; bus.clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    while (bus.busy && busy_cnt < N + 100) begin
      busy_cnt++;
      if (bus.clear_done) done_cnt++;
      if (busy_cnt == 500) plot1(1, 1, 3'b111, 1'b1);
      else if (busy_cnt == 600) begin
        bus.clear_req = 1'b1; step; bus.clear_req = 1'b0;
      end else step;
    end
    chk("clear_busy_cycles", busy_cnt, N);
    chk("clear_done_during_busy", done_cnt, 0);
    chk("clear_done_pulse", bus.clear_done, 1);
    step;
    chk("clear_done_one_cycle", bus.clear_done, 0);
    chk("clear_busy_low", bus.busy, 0);
    chk("drop_mid_clear", bus.drop_count, ref_drop);
    for (int i = 0; i < N; i++) ref_mem[i] = 3'b000;

    // Writes: directed, out-of-range, random
    plot1(5, 7, 3'b101, 1'b0);
    plot1(160, 3, 3'b111, 1'b0);
    plot1(10, 120, 3'b111, 1'b0);
    chk("drop_oor", bus.drop_count, ref_drop);
    for (int i = 0; i < 40; i++)
      plot1(int'($urandom_range(0, 199)), int'($urandom_range(0, 127)),
            3'($urandom_range(0, 7)), 1'b0);
    chk("drop_random", bus.drop_count, ref_drop);

    // Full frame plus wrap pixel
    push_raster(N + 1);
    bus.scan_en = 1'b1;
    cnt = 1;
    while (!bus.pix_valid && cnt < 50) begin
      step;
      cnt++;
    end
    chk("first_valid_cycle", cnt, PD + 1);
    drain("frame_drained");
    bus.scan_en = 1'b0;
    step;
    chk("scan_off_valid", bus.pix_valid, 0);

    // Restart from (0,0) after scan_en drop, then outputs hold
    push_raster(3);
    bus.scan_en = 1'b1;
    drain("restart_drained");
    bus.scan_en = 1'b0;
    for (int i = 0; i < 6; i++) step;
    chk("hold_pix_x", bus.pix_x, 2);
    chk("hold_pix_y", bus.pix_y, 0);
    chk("hold_pix_colour", bus.pix_colour, ref_mem[2]);

    // Saturation
    for (int i = 0; i < 300; i++) plot1(200, 5, 3'b001, 1'b0);
    chk("drop_saturate", bus.drop_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_frame_store.md
Name: pixel_frame_store

Overview:
- Receiving end of the plot interface driven by the game FSMs: accepts (x, y, colour, plot) pixel writes into a 160x120, 3-bit-per-pixel frame store.
- Reads the frame store back as a raster-order pixel stream for scanout, and for any later readback consumer such as collision checks.
- Provides a hardware clear-to-background fill with a busy/done handshake, and counts rejected writes.

Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 120, lines per frame.
- PIX_DIV, 4, clock cycles per scanout pixel; minimum 2.
- BG_COLOUR, 3'b000, colour written by clear.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- x  in  8  write column
- y  in  7  write row
- colour  in  3  write colour
- plot  in  1  write strobe, one pixel per cycle
- clear_req  in  1  start clear fill; level-sampled in IDLE
- scan_en  in  1  enable scanout stream
- busy  out  1  high while clearing
- clear_done  out  1  one-cycle pulse at end of clear
- pix_valid  out  1  one-cycle pulse per scanned pixel
- pix_x  out  8  scanned column
- pix_y  out  7  scanned row
- pix_colour  out  3  scanned colour
- line_start  out  1  with pix_valid when pix_x==0
- frame_start  out  1  with pix_valid when pix_x==0 and pix_y==0
- drop_count  out  8  rejected-write counter, saturating at 255

Behaviour:
- Reset: synchronous, applied on the clock edge while resetn==0.
  - All outputs 0; state IDLE; scan position (0,0); divider 0; drop_count 0.
  - Memory contents are not cleared by reset.
- Address is y*WIDTH + x, computed in 15 bits. Memory is single-write, single-read, with registered read (1 cycle).
- Write path:
  - In IDLE, a plot with x<WIDTH and y<HEIGHT writes colour on that edge.
  - A plot with x>=WIDTH or y>=HEIGHT is not written; drop_count increments, saturating at 255.
  - Addresses never wrap into another row.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clear_req==1. A plot in the same cycle is still written. busy=1 from the next cycle.
  - In CLEAR, one BG_COLOUR write per cycle to addresses 0..WIDTH*HEIGHT-1, so 19200 cycles at default.
  - After the last address: return to IDLE, busy=0, and clear_done=1 for exactly 1 cycle on the first IDLE cycle.
  - clear_req while in CLEAR is ignored; no restart.
  - Any plot during CLEAR is not written and increments drop_count.
  - Reset during CLEAR: IDLE, busy=0, no clear_done; the partially cleared memory is left as is.
- Scanout:
  - Divider counts 0..PIX_DIV-1 while scan_en==1.
  - scan_en==0 holds the divider at 0 and the scan position at (0,0), and forces pix_valid=0.
  - tick = scan_en && divider==PIX_DIV-1. On a tick edge, the read of the current (sx,sy) is issued and sx/sy advance.
  - The next cycle: pix_valid=1, with pix_x/pix_y set to the read position and pix_colour set to the stored data.
  - First pix_valid after scan_en rises comes PIX_DIV+1 cycles later.
- Raster order:
  - sx increments; at sx==WIDTH-1 it goes to 0 and sy increments.
  - At (WIDTH-1,HEIGHT-1) the position wraps to (0,0).
- Read/write collision: a read and a write to the same address on the same edge return the old data (read-first).
- Scanout runs during CLEAR and returns whatever the memory currently holds.
- pix_x, pix_y and pix_colour hold their last values while pix_valid==0.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> busy=0, pix_valid=0, drop_count=0, pix_x=0, pix_y=0.
- Single write and readback: plot (x=5, y=7, colour=3'b101) in IDLE, then scan_en=1 and capture the full frame -> pixel (5,7) returns 101 and every other pixel is unchanged.
- Out-of-range write: plot (160,3,3'b111), then (10,120,3'b111) -> drop_count=2, and pixels (0,4) and (10,0) are unchanged. Then 300 out-of-range plots -> drop_count=255.
- Clear with concurrent plot:
  - Write (20,20,3'b010), then assert clear_req for 1 cycle -> busy high for exactly 19200 cycles and one clear_done pulse; a scan then returns 3'b000 for all 19200 pixels.
  - A plot at (1,1) mid-clear -> not stored, drop_count+1.
- Scan timing and wrap: PIX_DIV=4, scan_en rises -> first pix_valid 5 cycles later with (0,0), frame_start=1 and line_start=1.
  - pix_valid recurs every 4 cycles.
  - Pixel 160 reports (0,1) with line_start=1.
  - After (159,119) the next pixel is (0,0) with frame_start=1.
- Reset mid-clear: assert resetn=0 at clear cycle 1000 -> busy=0 next cycle, no clear_done; clear_req afterwards runs a full 19200-cycle clear.
